// File: rtl/tqvp_vga_timing_gen.sv
// Parametrised video timing generator: pixel/line counters, registered sync and
// visible decode, line/frame strobes, frame counter and sticky scanline interrupt.
module tqvp_vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               hsync_pol,
  input  logic               vsync_pol,
  input  logic [CNT_W-1:0]   irq_line,
  input  logic               irq_clear,
  output logic               hsync,
  output logic               vsync,
  output logic               visible,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               irq
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // r_run remembers whether the previous edge was enabled, so the first enabled
  // edge presents the origin instead of advancing past it.
  logic               r_run;
  logic [CNT_W-1:0]   r_pix_x;
  logic [CNT_W-1:0]   r_pix_y;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_visible;
  logic               r_line_start;
  logic               r_frame_start;
  logic [FRAME_W-1:0] r_frame_count;
  logic               r_irq;

  logic [CNT_W-1:0]   w_nx;
  logic [CNT_W-1:0]   w_ny;
  logic               w_h_act;
  logic               w_v_act;
  logic               w_vis;
  logic               w_line_start;
  logic               w_frame_start;
  logic               w_irq_set;

  // Decode is done on the next counter values so every registered output
  // describes the coordinate presented alongside it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_nx = '0;
    w_ny = '0;
    if (enable && r_run) begin
      if (r_pix_x == H_LAST) begin
        w_ny = (r_pix_y == V_LAST) ? '0 : r_pix_y + 1'b1;
      end else begin
        w_nx = r_pix_x + 1'b1;
        w_ny = r_pix_y;
      end
    end
  end

  assign w_h_act       = enable && (w_nx >= HS_FIRST) && (w_nx <= HS_LAST);
  assign w_v_act       = enable && (w_ny >= VS_FIRST) && (w_ny <= VS_LAST);
  assign w_vis         = enable && (w_nx < H_VIS) && (w_ny < V_VIS);
  assign w_line_start  = enable && (w_nx == '0);
  assign w_frame_start = w_line_start && (w_ny == '0);
  assign w_irq_set     = r_line_start && (r_pix_y == irq_line);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous,
  // active-low reset that clears every register without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_visible     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_run         <= enable;
      r_pix_x       <= w_nx;
      r_pix_y       <= w_ny;
      r_hsync       <= (w_h_act == hsync_pol);
      r_vsync       <= (w_v_act == vsync_pol);
      r_visible     <= w_vis;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
      if (w_frame_start) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
      // Set has priority over a coincident clear.
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (irq_clear) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign visible     = r_visible;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;
  assign irq         = r_irq;

endmodule

// File: tb/tb_tqvp_vga_timing_gen.sv
// Bench for tqvp_vga_timing_gen: a time-since-enable reference model checked every
// cycle, plus directed literal checks for the scenarios with known answers.
module tb_tqvp_vga_timing_gen;

  localparam int HV = 8, HF = 2, HS = 2, HB = 2;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int CW = 4, FW = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          hsync_pol = 1'b1;
  logic          vsync_pol = 1'b1;
  logic [CW-1:0] irq_line = 4'd3;
  logic          irq_clear = 1'b0;

  logic          hsync, vsync, visible, line_start, frame_start, irq;
  logic [CW-1:0] pix_x, pix_y;
  logic [FW-1:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  tqvp_vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CNT_W(CW), .FRAME_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
    .irq_line(irq_line), .irq_clear(irq_clear),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .pix_x(pix_x), .pix_y(pix_y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: outputs follow from the number of enabled edges since the
  // last (re)start, t, via x = t mod HT and y = (t div HT) mod VT.
  bit m_run, m_ls, m_fs, m_vis, m_hs, m_vs, m_irq;
  int m_t, m_x, m_y, m_fc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_x = 0; m_y = 0; m_fc = 0;
      m_ls = 0; m_fs = 0; m_vis = 0; m_hs = 0; m_vs = 0; m_irq = 0;
    end else begin
      if (m_ls && m_y == int'(irq_line)) m_irq = 1;
      else if (irq_clear)                m_irq = 0;
      if (enable) begin
        m_t   = m_run ? m_t + 1 : 0;
        m_run = 1;
        m_x   = m_t % HT;
        m_y   = (m_t / HT) % VT;
        m_ls  = (m_x == 0);
        m_fs  = m_ls && (m_y == 0);
        m_vis = (m_x < HV) && (m_y < VV);
        m_hs  = ((m_x >= HV + HF) && (m_x < HV + HF + HS)) == hsync_pol;
        m_vs  = ((m_y >= VV + VF) && (m_y < VV + VF + VS)) == vsync_pol;
        if (m_fs) m_fc = (m_fc + 1) % (1 << FW);
      end else begin
        m_run = 0; m_t = 0; m_x = 0; m_y = 0;
        m_ls = 0; m_fs = 0; m_vis = 0;
        m_hs = !hsync_pol;
        m_vs = !vsync_pol;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on)
      check("cycle {hs,vs,vis,ls,fs,irq,x,y,fc}",
            {15'd0, hsync, vsync, visible, line_start, frame_start, irq, pix_x, pix_y, frame_count},
            {15'd0, m_hs, m_vs, m_vis, m_ls, m_fs, m_irq, CW'(m_x), CW'(m_y), FW'(m_fc)});
  end

  task automatic wait_pix(input int x, input int y);
    bit found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (int'(pix_x) == x && int'(pix_y) == y) begin
        found = 1;
        break;
      end
    end
    if (!found) check($sformatf("timeout waiting for (%0d,%0d)", x, y), 0, 1);
  endtask

  initial begin
    int cnt;
    int prev_fc;
    logic [FW-1:0] held_fc;

    // Reset with inverted polarity: syncs must still read 0 until the first edge.
    hsync_pol = 0;
    vsync_pol = 0;
    #1 rst_n = 0;
    cmp_on = 1;
    #22;
    check("reset outputs", {hsync, vsync, visible, pix_x, pix_y, frame_count, irq}, '0);
    rst_n = 1;
    @(negedge clk);
    check("disabled hsync inactive (pol=0)", hsync, 1);
    check("disabled vsync inactive (pol=0)", vsync, 1);
    hsync_pol = 1;
    vsync_pol = 1;
    @(negedge clk);

    // Start: first edge presents the origin with both strobes.
    enable = 1;
    @(negedge clk);
    check("first pix_x", pix_x, 0);
    check("first pix_y", pix_y, 0);
    check("first frame_start", frame_start, 1);
    check("first frame_count", frame_count, 1);
    check("first visible", visible, 1);

    wait_pix(13, 0);
    @(negedge clk);
    check("wrap pix_x", pix_x, 0);
    check("wrap pix_y", pix_y, 1);

    wait_pix(10, 1);
    check("hsync at x=10", hsync, 1);
    check("visible at x=10", visible, 0);
    wait_pix(0, 3);
    check("irq before set", irq, 0);
    @(negedge clk);
    check("irq set one edge after (0,3)", irq, 1);
    wait_pix(12, 3);
    check("hsync at x=12", hsync, 0);
    wait_pix(3, 5);
    check("vsync at y=5", vsync, 1);
    check("visible at y=5", visible, 0);

    irq_clear = 1;
    @(negedge clk);
    irq_clear = 0;
    check("irq cleared", irq, 0);

    irq_clear = 1;
    wait_pix(0, 3);
    @(negedge clk);
    check("irq set wins over clear", irq, 1);
    irq_clear = 0;

    // Frame period measured between consecutive frame_start strobes.
    wait_pix(0, 0);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cnt++;
      if (frame_start) break;
    end
    check("frame_start period", cnt, HT * VT);

    hsync_pol = 0;
    vsync_pol = 0;
    wait_pix(10, 5);
    check("inverted hsync active", hsync, 0);
    check("inverted vsync active", vsync, 0);
    wait_pix(4, 1);
    check("inverted hsync idle", hsync, 1);
    hsync_pol = 1;
    @(negedge clk);
    check("mid-line hsync_pol flip", hsync, 0);
    vsync_pol = 1;

    irq_line = 4'd9;
    irq_clear = 1;
    @(negedge clk);
    irq_clear = 0;
    repeat (2 * HT * VT) @(negedge clk);
    check("irq_line beyond V_TOTAL never sets", irq, 0);

    prev_fc = int'(frame_count);
    for (int i = 0; i < 10; i++) begin
      wait_pix(0, 0);
      if (frame_count == 0) break;
      prev_fc = int'(frame_count);
    end
    check("frame_count wrap to 0", frame_count, 0);
    check("frame_count before wrap", prev_fc, 7);

    // Randomized stretch; every cycle is checked against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      irq_clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) irq_line = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) hsync_pol = ~hsync_pol;
      if ($urandom_range(0, 29) == 0) vsync_pol = ~vsync_pol;
      if ($urandom_range(0, 99) == 0) enable = ~enable;
    end
    irq_clear = 0;
    hsync_pol = 1;
    vsync_pol = 1;
    enable = 1;
    @(negedge clk);

    // Disable mid-line, then restart.
    wait_pix(5, 2);
    held_fc = frame_count;
    enable = 0;
    @(negedge clk);
    check("disable pix_x", pix_x, 0);
    check("disable pix_y", pix_y, 0);
    check("disable syncs inactive", {hsync, vsync}, 2'b00);
    check("disable strobes", {line_start, frame_start, visible}, 3'b000);
    check("disable frame_count held", frame_count, held_fc);
    @(negedge clk);
    enable = 1;
    @(negedge clk);
    check("re-enable frame_start", frame_start, 1);
    check("re-enable origin", {pix_x, pix_y}, 0);
    check("re-enable frame_count", frame_count, FW'(held_fc + 1'b1));

    // Asynchronous reset mid-line, away from any clock edge.
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async reset outputs",
          {hsync, vsync, visible, line_start, frame_start, irq, pix_x, pix_y, frame_count}, '0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tqvp_vga_timing_gen.md
# tqvp_vga_timing_gen

Parametrised video timing generator for TinyQV display peripherals. It replaces fixed-mode sync generation with compile-time H/V timing. It also adds an enable, run-time sync polarity, a frame counter, line/frame strobes and a programmable scanline interrupt. It sits between the peripheral register file, which drives `enable`, the polarity bits, `irq_line` and `irq_clear`, and the pixel generators, which consume `pix_x`, `pix_y`, `visible` and the strobes.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CNT_W`, 11, width of the pixel and line counters; must hold H_TOTAL-1 and V_TOTAL-1
- `FRAME_W`, 16, frame counter width

Ports:
- `clk` in 1: single clock for the whole block
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: 1 = run, 0 = hold the counters at the origin
- `hsync_pol` in 1: 1 = hsync active-high, 0 = active-low
- `vsync_pol` in 1: same meaning, for vsync
- `irq_line` in CNT_W: scanline that raises the interrupt
- `irq_clear` in 1: clears `irq`
- `hsync` out 1: horizontal sync, polarity applied
- `vsync` out 1: vertical sync, polarity applied
- `visible` out 1: current pixel is inside the active area
- `pix_x` out CNT_W: current pixel column
- `pix_y` out CNT_W: current line
- `line_start` out 1: strobe, high when `pix_x`==0
- `frame_start` out 1: strobe, high when `pix_x`==0 and `pix_y`==0
- `frame_count` out FRAME_W: number of frames started
- `irq` out 1: sticky scanline interrupt

## Operation
Derived totals:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK
- V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK

Counting:
- All outputs are registered.
- `pix_x` and `pix_y` are the counters themselves.
- All decoded outputs describe the `pix_x`/`pix_y` value presented in the same cycle.
- Run state:
  - `pix_x` counts 0..H_TOTAL-1, then wraps to 0.
  - `pix_y` increments on each `pix_x` wrap and counts 0..V_TOTAL-1, then wraps to 0.

Decoded outputs:
- `visible` = (`pix_x` < H_VISIBLE) and (`pix_y` < V_VISIBLE).
- hsync is active when `pix_x` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1].
- vsync is active when `pix_y` is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1].
- The output level is the active flag when pol=1, and its inverse when pol=0.
- A polarity change is visible on the next edge.

Enable:
- enable=0 forces these values on every edge, in any phase:
  - `pix_x`=`pix_y`=0
  - `visible`=0, `line_start`=0, `frame_start`=0
  - hsync/vsync at their inactive level
- `frame_count` and `irq` hold while disabled.
- The first edge that samples enable=1 presents (0,0) with `line_start`=`frame_start`=1. Each later edge advances one pixel.
- Disabling mid-frame abandons that frame. Re-enabling always restarts at (0,0).

Frame counter:
- `frame_count` increments by 1, modulo 2^FRAME_W, on each edge that presents `frame_start`=1.
- It therefore reads 1 throughout the first frame.

Interrupt:
- Set condition: a cycle in which `line_start`=1 and `pix_y`==`irq_line`.
- `irq` rises on the edge after that cycle, then stays high.
- `irq_clear` sampled high clears `irq` on that edge.
- If set and clear coincide, set wins.
- If `irq_line` >= V_TOTAL, `irq` never sets.

Reset values:
- All outputs 0, including hsync/vsync, regardless of polarity inputs.
- Counters hold 0.
- After `rst_n` releases with enable=0, hsync/vsync go to their inactive level on the first edge.

## Timing
- Latency: `enable` rising to first valid pixel is 1 edge.
- Latency: set condition to `irq` high is 1 edge; `irq_clear` to `irq` low is 1 edge.
- Frame period is H_TOTAL×V_TOTAL clocks; the defaults give 800×525 = 420000.
- `line_start` and `frame_start` are each exactly one clock wide.
- `frame_start` recurs every H_TOTAL×V_TOTAL clocks.
- Asserting `rst_n` low mid-frame clears every register immediately, with no clock required.

## Test plan
Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), CNT_W=4, FRAME_W=3, polarity 1/1 unless stated.

- Reset release, then enable=1 → first edge `pix`=(0,0), `frame_start`=1, `frame_count`=1, `visible`=1.
  - `pix_x` reaches 13 then wraps to 0 with `pix_y`=1.
  - `frame_start` recurs after exactly 98 clocks.
- Sync decode → hsync=1 only at `pix_x`=10..11.
  - vsync=1 only at `pix_y`=5, for all 14 pixels of that line.
  - `visible`=0 for `pix_x`>=8 or `pix_y`>=4.
- hsync_pol=0, vsync_pol=0 → both sync outputs are exact inversions of the previous run.
  - A mid-line polarity flip takes effect on the next edge.
- `irq_line`=3 → `irq` rises one edge after (`pix_x`=0, `pix_y`=3).
  - Pulsing `irq_clear` drops it on the next edge.
  - `irq_clear` held high through (0,3) → `irq` still sets.
  - `irq_line`=9 → never sets.
- Run 8 frames → `frame_count` wraps 7→0 on the 8th `frame_start`.
- Mid-line disturbances:
  - enable=0 at (5,2) → next edge `pix`=(0,0), hsync/vsync inactive, `frame_count` held; re-enable restarts at (0,0) with `frame_start`=1.
  - `rst_n` low mid-line → all outputs 0 asynchronously.
